// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the execute stage of the PIC-style core:
//   - ALU_WIDTH : datapath width. Fixed at 8 because the bit index is 3 bits.
//   - alu_op_e  : the 16 ALU function codes.
//   - c_update  : 1 when a function writes the carry flag.
//   - z_update  : 1 when a function writes the zero flag.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_WIDTH = 8;

   typedef enum logic [3:0] {
      OP_PASSB = 4'd0,
      OP_ADD   = 4'd1,
      OP_SUB   = 4'd2,
      OP_AND   = 4'd3,
      OP_IOR   = 4'd4,
      OP_XOR   = 4'd5,
      OP_COM   = 4'd6,
      OP_INC   = 4'd7,
      OP_DEC   = 4'd8,
      OP_RLF   = 4'd9,
      OP_RRF   = 4'd10,
      OP_SWAP  = 4'd11,
      OP_BCF   = 4'd12,
      OP_BSF   = 4'd13,
      OP_CLR   = 4'd14,
      OP_PASSA = 4'd15
   } alu_op_e;

   // Only the arithmetic and rotate functions produce a carry.
   function automatic logic c_update(input alu_op_e op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_RLF) || (op == OP_RRF);
   endfunction

   // Rotates, swap, bit set/clear and PASSA leave Z untouched.
   function automatic logic z_update(input alu_op_e op);
      return !((op == OP_RLF) || (op == OP_RRF) || (op == OP_SWAP) ||
               (op == OP_BCF) || (op == OP_BSF) || (op == OP_PASSA));
   endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational 16-function ALU.
// Ports:
//   a          in  operand A (W register)
//   b          in  operand B (file value or literal)
//   cin        in  registered carry, used as the rotate input
//   inst       in  function code (alu_op_e)
//   bit_number in  bit index for BCF/BSF
//   r          out function result
//   cout       out carry produced by the function (equals cin when none)
//   c_upd      out 1 when the carry flag should be written
//   z_upd      out 1 when the zero flag should be written
// -----------------------------------------------------------------------------
module alu_core
   import alu_pkg::*;
(
   input  logic [ALU_WIDTH-1:0] a,
   input  logic [ALU_WIDTH-1:0] b,
   input  logic                 cin,
   input  logic [3:0]           inst,
   input  logic [2:0]           bit_number,
   output logic [ALU_WIDTH-1:0] r,
   output logic                 cout,
   output logic                 c_upd,
   output logic                 z_upd
);

   alu_op_e              op;
   logic [ALU_WIDTH:0]   sum;      // one extra bit for carry / borrow
   logic [ALU_WIDTH-1:0] bit_mask;

   assign op       = alu_op_e'(inst);
   assign bit_mask = {{(ALU_WIDTH-1){1'b0}}, 1'b1} << bit_number;
   assign c_upd    = c_update(op);
   assign z_upd    = z_update(op);

   always_comb begin
      r    = b;
      cout = cin;
      sum  = '0;
      case (op)
         OP_PASSB: r = b;
         OP_ADD: begin
            sum  = {1'b0, a} + {1'b0, b};
            r    = sum[ALU_WIDTH-1:0];
            cout = sum[ALU_WIDTH];
         end
         OP_SUB: begin
            // b - a: the top bit is the borrow, carry is its inverse.
            sum  = {1'b0, b} - {1'b0, a};
            r    = sum[ALU_WIDTH-1:0];
            cout = ~sum[ALU_WIDTH];
         end
         OP_AND:   r = a & b;
         OP_IOR:   r = a | b;
         OP_XOR:   r = a ^ b;
         OP_COM:   r = ~b;
         OP_INC:   r = b + 1'b1;
         OP_DEC:   r = b - 1'b1;
         OP_RLF: begin
            r    = {b[ALU_WIDTH-2:0], cin};
            cout = b[ALU_WIDTH-1];
         end
         OP_RRF: begin
            r    = {cin, b[ALU_WIDTH-1:1]};
            cout = b[0];
         end
         OP_SWAP:  r = {b[3:0], b[7:4]};
         OP_BCF:   r = b & ~bit_mask;
         OP_BSF:   r = b | bit_mask;
         OP_CLR:   r = '0;
         OP_PASSA: r = a;
      endcase
   end

endmodule

// File: rtl/alu_datapath.sv
// -----------------------------------------------------------------------------
// alu_datapath
// 8-bit execute stage: operand-B mux, ALU, result/carry/zero registers and the
// data-bus driver. One clock with phase enables replaces the Q1..Q4 clocks.
// Ports:
//   clk          in  system clock, rising edge
//   reset        in  asynchronous active-low reset
//   inst         in  ALU function code
//   bit_number   in  bit index for BCF/BSF
//   switch_a_m   in  operand-B select: 1 = literal k, 0 = file value f
//   f, k, w      in  file value, literal, W register (operand A)
//   exec_en      in  execute phase: capture result and flags
//   drive_en     in  bus-drive phase: put the result on the bus
//   b            out selected operand B (combinational)
//   ans          out registered result
//   carry, zero  out registered flags
//   data_bus_out out ans while driving, otherwise 0
//   data_bus_oe  out bus output enable (tristate built above this block)
// -----------------------------------------------------------------------------
module alu_datapath
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH   // only 8 is supported
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       inst,
   input  logic [2:0]       bit_number,
   input  logic             switch_a_m,
   input  logic [WIDTH-1:0] f,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] w,
   input  logic             exec_en,
   input  logic             drive_en,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] ans,
   output logic             carry,
   output logic             zero,
   output logic [WIDTH-1:0] data_bus_out,
   output logic             data_bus_oe
);

   logic [WIDTH-1:0] r;
   logic             cout;
   logic             c_upd;
   logic             z_upd;

   logic [WIDTH-1:0] ans_d,   ans_q;
   logic             carry_d, carry_q;
   logic             zero_d,  zero_q;

   assign b = switch_a_m ? k : f;

   alu_core u_core (
      .a          (w),
      .b          (b),
      .cin        (carry_q),
      .inst       (inst),
      .bit_number (bit_number),
      .r          (r),
      .cout       (cout),
      .c_upd      (c_upd),
      .z_upd      (z_upd)
   );

   always_comb begin
      ans_d   = ans_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      if (exec_en) begin
         ans_d = r;
         if (c_upd) carry_d = cout;
         if (z_upd) zero_d  = (r == '0);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ans_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         ans_q   <= ans_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

   assign ans   = ans_q;
   assign carry = carry_q;
   assign zero  = zero_q;

   // Bus shows the registered result, so a drive in the same cycle as an
   // execute still presents the previous answer.
   assign data_bus_oe  = drive_en;
   assign data_bus_out = drive_en ? ans_q : '0;

endmodule

// File: tb/tb_alu_datapath.sv
module tb_alu_datapath;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] inst;
   logic [2:0] bit_number;
   logic       switch_a_m;
   logic [7:0] f, k, w;
   logic       exec_en, drive_en;
   logic [7:0] b, ans, data_bus_out;
   logic       carry, zero, data_bus_oe;

   int n_assert = 0;
   int n_fail   = 0;

   alu_datapath #(.WIDTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .inst         (inst),
      .bit_number   (bit_number),
      .switch_a_m   (switch_a_m),
      .f            (f),
      .k            (k),
      .w            (w),
      .exec_en      (exec_en),
      .drive_en     (drive_en),
      .b            (b),
      .ans          (ans),
      .carry        (carry),
      .zero         (zero),
      .data_bus_out (data_bus_out),
      .data_bus_oe  (data_bus_oe)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One execute pulse; outputs are sampled 1 time unit after the edge.
   task automatic exec_op(input logic [3:0] op, input logic [7:0] wv, input logic [7:0] fv,
                          input logic [7:0] kv, input logic sel, input logic [2:0] bn);
      inst = op; w = wv; f = fv; k = kv; switch_a_m = sel; bit_number = bn;
      exec_en = 1'b1;
      tick();
      exec_en = 1'b0;
      $display("op=%0d w=%h f=%h k=%h sel=%0b bit=%0d -> ans=%h c=%0b z=%0b",
               op, wv, fv, kv, sel, bn, ans, carry, zero);
   endtask

   task automatic check_state(input string tag, input logic [7:0] ea, input logic ec, input logic ez);
      check({tag, "_ans"},   ans,   ea);
      check({tag, "_carry"}, {7'd0, carry}, {7'd0, ec});
      check({tag, "_zero"},  {7'd0, zero},  {7'd0, ez});
   endtask

   initial begin
      reset = 1'b0; inst = 4'd0; bit_number = 3'd0; switch_a_m = 1'b0;
      f = 8'h00; k = 8'h00; w = 8'h00; exec_en = 1'b0; drive_en = 1'b0;

      // Reset held low: state stays zero even with exec pulses.
      tick(); tick();
      check_state("reset", 8'h00, 1'b0, 1'b0);
      check("reset_oe", {7'd0, data_bus_oe}, 8'h00);
      exec_op(OP_ADD, 8'h80, 8'h80, 8'h00, 1'b0, 3'd0);
      check_state("reset_exec_add", 8'h00, 1'b0, 1'b0);
      exec_op(OP_PASSB, 8'h00, 8'hAA, 8'h00, 1'b0, 3'd0);
      check_state("reset_exec_passb", 8'h00, 1'b0, 1'b0);

      reset = 1'b1;
      tick();
      check_state("post_reset", 8'h00, 1'b0, 1'b0);

      // ADD via literal: b is combinational, ans appears after the edge.
      inst = OP_ADD; w = 8'h25; k = 8'h3A; switch_a_m = 1'b1; #1;
      check("mux_literal", b, 8'h3A);
      exec_op(OP_ADD, 8'h25, 8'h00, 8'h3A, 1'b1, 3'd0);
      check_state("add_lit", 8'h5F, 1'b0, 1'b0);
      switch_a_m = 1'b0; f = 8'h99; #1;
      check("mux_file", b, 8'h99);

      exec_op(OP_ADD,  8'h80, 8'h80, 8'h00, 1'b0, 3'd0); check_state("add_ovf",   8'h00, 1'b1, 1'b1);
      exec_op(OP_SUB,  8'h05, 8'h03, 8'h00, 1'b0, 3'd0); check_state("sub_borrow",8'hFE, 1'b0, 1'b0);
      exec_op(OP_SUB,  8'h03, 8'h03, 8'h00, 1'b0, 3'd0); check_state("sub_eq",    8'h00, 1'b1, 1'b1);
      exec_op(OP_RLF,  8'h00, 8'h81, 8'h00, 1'b0, 3'd0); check_state("rlf",       8'h03, 1'b1, 1'b1);
      exec_op(OP_RRF,  8'h00, 8'h02, 8'h00, 1'b0, 3'd0); check_state("rrf",       8'h81, 1'b0, 1'b1);
      exec_op(OP_BSF,  8'h00, 8'h00, 8'h00, 1'b0, 3'd6); check_state("bsf6",      8'h40, 1'b0, 1'b1);
      exec_op(OP_XOR,  8'hF0, 8'h0F, 8'h00, 1'b0, 3'd0); check_state("xor",       8'hFF, 1'b0, 1'b0);
      exec_op(OP_SWAP, 8'h00, 8'hA5, 8'h00, 1'b0, 3'd0); check_state("swap",      8'h5A, 1'b0, 1'b0);
      exec_op(OP_BCF,  8'h00, 8'h01, 8'h00, 1'b0, 3'd0); check_state("bcf0_zhold",8'h00, 1'b0, 1'b0);
      exec_op(OP_BCF,  8'h00, 8'hFF, 8'h00, 1'b0, 3'd6); check_state("bcf6",      8'hBF, 1'b0, 1'b0);
      exec_op(OP_INC,  8'h00, 8'hFF, 8'h00, 1'b0, 3'd3); check_state("inc_wrap",  8'h00, 1'b0, 1'b1);
      exec_op(OP_DEC,  8'h00, 8'h00, 8'h00, 1'b0, 3'd5); check_state("dec_wrap",  8'hFF, 1'b0, 1'b0);
      exec_op(OP_COM,  8'h00, 8'h12, 8'hFF, 1'b1, 3'd0); check_state("com_lit",   8'h00, 1'b0, 1'b1);
      exec_op(OP_IOR,  8'h3C, 8'hC3, 8'h00, 1'b0, 3'd0); check_state("ior",       8'hFF, 1'b0, 1'b0);
      exec_op(OP_AND,  8'h3C, 8'hC3, 8'h00, 1'b0, 3'd0); check_state("and",       8'h00, 1'b0, 1'b1);
      exec_op(OP_PASSA,8'h77, 8'h00, 8'h00, 1'b0, 3'd0); check_state("passa",     8'h77, 1'b0, 1'b1);
      exec_op(OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b0, 3'd0); check_state("add_c",     8'h00, 1'b1, 1'b1);
      exec_op(OP_CLR,  8'h55, 8'h66, 8'h00, 1'b0, 3'd0); check_state("clr",       8'h00, 1'b1, 1'b1);
      exec_op(OP_PASSB,8'h00, 8'h80, 8'h00, 1'b0, 3'd0); check_state("passb",     8'h80, 1'b1, 1'b0);

      // Bus drive.
      exec_op(OP_ADD, 8'h25, 8'h00, 8'h3A, 1'b1, 3'd0);
      check_state("add_lit2", 8'h5F, 1'b0, 1'b0);
      drive_en = 1'b1; #1;
      check("drive_oe",  {7'd0, data_bus_oe}, 8'h01);
      check("drive_out", data_bus_out, 8'h5F);
      drive_en = 1'b0; #1;
      check("idle_oe",  {7'd0, data_bus_oe}, 8'h00);
      check("idle_out", data_bus_out, 8'h00);

      // Hold with exec_en low while inputs change.
      inst = OP_CLR; w = 8'hFF; f = 8'hFF; k = 8'h00; switch_a_m = 1'b0;
      tick();
      inst = OP_SUB; w = 8'h01; f = 8'h00;
      tick();
      check_state("hold", 8'h5F, 1'b0, 1'b0);

      // Drive and execute together: old value now, new value next cycle.
      drive_en = 1'b1;
      inst = OP_PASSB; f = 8'hC3; switch_a_m = 1'b0; exec_en = 1'b1; #1;
      check("drive_exec_old", data_bus_out, 8'h5F);
      @(posedge clk); #1;
      exec_en = 1'b0;
      check("drive_exec_new", data_bus_out, 8'hC3);
      drive_en = 1'b0;

      // Asynchronous reset between clock edges.
      #2 reset = 1'b0; #1;
      check_state("async_reset", 8'h00, 1'b0, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      check_state("after_async", 8'h00, 1'b0, 1'b0);
      exec_op(OP_PASSB, 8'h00, 8'h3C, 8'h00, 1'b0, 3'd0);
      check_state("first_capture", 8'h3C, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
